cv32e40p_tmr_voter_seq: RTL and testbench
=========================================

Name: cv32e40p_tmr_voter_seq

Overview:
Registered N-modular-redundancy voter that generalises the combinational TMR voter to an odd channel count, with one-cycle pipelined output. It adds per-channel fault attribution, a saturating mismatch counter and a per-channel health state machine that retires persistently faulty channels from the vote. It sits between replicated pipeline-stage copies in the core and the downstream consumer, and also feeds the fault-reporting CSRs.

Parameters:
DATA_WIDTH, 32, width of each voted word
NUM_CH, 3, number of redundant channels; odd, 3..7 (elaboration error otherwise)
CNT_WIDTH, 8, width of the saturating mismatch counter
PERSIST_THRESH, 4, consecutive faulted valid words before a channel is retired; 1..15

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-high reset
valid_i  in  1  data_i holds a word to vote this cycle
data_i  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
clr_i  in  1  clears counter, health states and sticky flags
valid_o  out  1  data_o valid; valid_i delayed by 1 cycle
data_o  out  DATA_WIDTH  voted word, registered
mismatch_o  out  1  registered; at least one active channel differed from the voted word
ch_fault_o  out  NUM_CH  registered; bit c is 1 when active channel c differed from the voted word
uncorrectable_o  out  1  registered; a tie occurred or there were no active channels
ch_failed_o  out  NUM_CH  bit c is 1 when channel c is in the FAILED state
err_cnt_o  out  CNT_WIDTH  count of valid words with mismatch_o set; saturates at all-ones

Behaviour:
- Reset (rst=1 at a clk edge): every output is 0; all channels go to HEALTHY; the consecutive-fault counters go to 0.
- Active set A: channels not in FAILED; nA = |A|.
- Vote, per bit: the output bit is 1 if the number of active channels with a 1 is greater than nA/2.
  - Bit tie (nA even, exact half): take the bit of the lowest-index active channel and flag a tie.
  - nA=0: data_o takes channel 0 and uncorrectable_o=1.
- Latency: 1 cycle. On valid_i at cycle t, data_o, mismatch_o, ch_fault_o and uncorrectable_o update at t+1 with valid_o=1.
- When valid_i=0, the next cycle has valid_o=0 and mismatch_o, ch_fault_o, uncorrectable_o = 0. data_o holds its last value.
- No backpressure; a new word can arrive every cycle.
- Fault attribution: ch_fault_o[c] = (c in A) and (data_c differs from the voted word). FAILED channels never raise ch_fault_o.
- err_cnt_o: +1 per valid word with mismatch; saturates at 2^CNT_WIDTH-1 and never wraps.
- Per-channel health FSM, advances only on valid words:
  - HEALTHY: a fault moves to SUSPECT with consec=1. A clean word stays HEALTHY.
  - SUSPECT: a fault increments consec; reaching PERSIST_THRESH moves to FAILED. A clean word returns to HEALTHY with consec=0.
  - FAILED: sticky; left only via clr_i or rst.
  - ch_failed_o updates in the same cycle as the state transition, so the channel is excluded from the vote of the next word.
- clr_i has priority over counter and FSM updates in the same cycle.
  - Counter, FSMs and consec are zeroed.
  - A simultaneous valid word is still voted and reported on data_o, mismatch_o and ch_fault_o.
  - That word's events are dropped from the counter and the FSMs.
- rst mid-stream: a word captured in that cycle is discarded; valid_o=0 on the next cycle.
- mismatch_o=1 whenever any ch_fault_o bit is set; uncorrectable_o is independent of mismatch_o.

Optional Feature:
CV32E40P_TMR_FAULT_INJECT_EN.
- Defined: adds ports inj_en_i (1), inj_ch_i ($clog2(NUM_CH)) and inj_mask_i (DATA_WIDTH). When inj_en_i=1, the selected channel's word is XORed with inj_mask_i before voting, attribution and the FSMs. An inj_ch_i value of NUM_CH or above has no effect.
- Undefined: the ports are absent and behaviour is identical to inj_en_i=0.

Test Plan:
- Agreement: NUM_CH=3, all channels 0xDEADBEEF, valid_i=1 -> next cycle data_o=0xDEADBEEF, valid_o=1, mismatch_o=0, ch_fault_o=3'b000, err_cnt_o=0.
- Single fault: ch1=0xDEADBEEE, others 0xDEADBEEF -> data_o=0xDEADBEEF, ch_fault_o=3'b010, mismatch_o=1, err_cnt_o=1, ch1 SUSPECT.
- Persistence: ch1 faulted on 4 consecutive valid words -> ch_failed_o=3'b010 after the 4th word, err_cnt_o=4. Then ch0=0x1, ch2=0x0 -> tie, data_o=0x1 (from ch0), uncorrectable_o=1, ch_fault_o=3'b100.
- Recovery: ch2 faulted on 3 words, then 1 clean word, then 3 more faulted words -> ch_failed_o stays 0; err_cnt_o=6.
- Saturation/clear: CNT_WIDTH=2, 5 mismatching words -> err_cnt_o=3. Then clr_i together with a mismatching word -> err_cnt_o=0, ch_failed_o=0, that word still shows mismatch_o=1.
- Reset mid-stream: a valid word at the same edge as rst=1 -> next cycle all outputs 0, valid_o=0; with the macro defined, inj_ch_i=0, inj_mask_i=0x1 on equal inputs -> ch_fault_o=3'b001.

Source files
------------

// File: rtl/cv32e40p_tmr_voter_seq.sv
// Registered N-modular-redundancy voter with fault attribution, a saturating mismatch counter and per-channel health FSMs.
// Optional fault-injection ports are enabled by defining CV32E40P_TMR_FAULT_INJECT_EN.
`default_nettype none

module cv32e40p_tmr_voter_seq #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CH         = 3,
  parameter int CNT_WIDTH      = 8,
  parameter int PERSIST_THRESH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef CV32E40P_TMR_FAULT_INJECT_EN
  input  logic                         inj_en_i,
  input  logic [$clog2(NUM_CH)-1:0]    inj_ch_i,
  input  logic [DATA_WIDTH-1:0]        inj_mask_i,
`endif
  input  logic                         valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic                         clr_i,
  output logic                         valid_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         mismatch_o,
  output logic [NUM_CH-1:0]            ch_fault_o,
  output logic                         uncorrectable_o,
  output logic [NUM_CH-1:0]            ch_failed_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o
);

  localparam int IW = $clog2(NUM_CH);
  localparam int NW = 4;

  generate
    if ((NUM_CH < 3) || (NUM_CH > 7) || ((NUM_CH % 2) == 0)) begin : g_bad_num_ch
      $error("NUM_CH must be odd and within 3..7");
    end
    if ((PERSIST_THRESH < 1) || (PERSIST_THRESH > 15)) begin : g_bad_thresh
      $error("PERSIST_THRESH must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } health_t;

  health_t                 state  [NUM_CH];
  logic [3:0]              consec [NUM_CH];
  logic [DATA_WIDTH-1:0]   word   [NUM_CH];
  logic [NUM_CH-1:0]       active;
  logic [NW-1:0]           n_act;
  logic [NW-1:0]           ones;
  logic [IW-1:0]           first_idx;
  logic [DATA_WIDTH-1:0]   voted;
  logic                    tie;
  logic                    uncorr;
  logic [NUM_CH-1:0]       fault;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      word[c]        = data_i[c*DATA_WIDTH +: DATA_WIDTH];
`ifdef CV32E40P_TMR_FAULT_INJECT_EN
      if (inj_en_i && (int'(inj_ch_i) == c)) begin
        word[c] = word[c] ^ inj_mask_i;
      end
`endif
      ch_failed_o[c] = (state[c] == FAILED);
      active[c]      = (state[c] != FAILED);
    end
  end

  // Scanning downwards leaves first_idx on the lowest-index active channel.
  always_comb begin
    n_act     = '0;
    first_idx = '0;
    ones      = '0;
    voted     = '0;
    tie       = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (active[c]) begin
        n_act     = n_act + NW'(1);
        first_idx = IW'(c);
      end
    end
    for (int b = 0; b < DATA_WIDTH; b++) begin
      ones = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (active[c] && word[c][b]) begin
          ones = ones + NW'(1);
        end
      end
      if ({ones[NW-2:0], 1'b0} > n_act) begin
        voted[b] = 1'b1;
      end else if ({ones[NW-2:0], 1'b0} == n_act) begin
        voted[b] = word[first_idx][b];
        tie      = 1'b1;
      end
    end
    if (n_act == '0) begin
      voted = word[0];
      tie   = 1'b0;
    end
    uncorr = tie || (n_act == '0);
    for (int c = 0; c < NUM_CH; c++) begin
      fault[c] = active[c] && (word[c] != voted);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o         <= 1'b0;
      data_o          <= '0;
      mismatch_o      <= 1'b0;
      ch_fault_o      <= '0;
      uncorrectable_o <= 1'b0;
      err_cnt_o       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]  <= HEALTHY;
        consec[c] <= '0;
      end
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        data_o          <= voted;
        mismatch_o      <= |fault;
        ch_fault_o      <= fault;
        uncorrectable_o <= uncorr;
      end else begin
        mismatch_o      <= 1'b0;
        ch_fault_o      <= '0;
        uncorrectable_o <= 1'b0;
      end
      // A clear drops the events of a word voted in the same cycle.
      if (clr_i) begin
        err_cnt_o <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          state[c]  <= HEALTHY;
          consec[c] <= '0;
        end
      end else if (valid_i) begin
        if ((|fault) && (err_cnt_o != '1)) begin
          err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
        end
        for (int c = 0; c < NUM_CH; c++) begin
          case (state[c])
            HEALTHY: begin
              if (fault[c]) begin
                state[c]  <= (PERSIST_THRESH == 1) ? FAILED : SUSPECT;
                consec[c] <= 4'd1;
              end
            end
            SUSPECT: begin
              if (fault[c]) begin
                consec[c] <= consec[c] + 4'd1;
                if ((consec[c] + 4'd1) >= 4'(PERSIST_THRESH)) begin
                  state[c] <= FAILED;
                end
              end else begin
                state[c]  <= HEALTHY;
                consec[c] <= '0;
              end
            end
            FAILED: begin
              state[c] <= FAILED;
            end
            default: begin
              state[c]  <= HEALTHY;
              consec[c] <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_tmr_voter_seq.sv
// Self-checking bench for cv32e40p_tmr_voter_seq: directed scenarios then random words against a behavioural model.
`default_nettype none

module tb_cv32e40p_tmr_voter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [95:0] data_i;
  logic        clr_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        mismatch_o;
  logic [2:0]  ch_fault_o;
  logic        uncorrectable_o;
  logic [2:0]  ch_failed_o;
  logic [7:0]  err_cnt_o;
`ifdef CV32E40P_TMR_FAULT_INJECT_EN
  logic        inj_en;
  logic [1:0]  inj_ch;
  logic [31:0] inj_mask;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Behavioural reference state
  bit          m_failed [3];
  int          m_streak [3];
  int          m_cnt;
  bit          e_valid, e_mis, e_unc;
  logic [2:0]  e_fault;
  logic [31:0] e_data;

  cv32e40p_tmr_voter_seq dut (
    .clk             (clk),
    .rst             (rst),
`ifdef CV32E40P_TMR_FAULT_INJECT_EN
    .inj_en_i        (inj_en),
    .inj_ch_i        (inj_ch),
    .inj_mask_i      (inj_mask),
`endif
    .valid_i         (valid_i),
    .data_i          (data_i),
    .clr_i           (clr_i),
    .valid_o         (valid_o),
    .data_o          (data_o),
    .mismatch_o      (mismatch_o),
    .ch_fault_o      (ch_fault_o),
    .uncorrectable_o (uncorrectable_o),
    .ch_failed_o     (ch_failed_o),
    .err_cnt_o       (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compute what the next edge must produce from the pre-edge model state, then update the model.
  task automatic model(input bit v, input bit cl, input bit r, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2);
    logic [31:0] w [3];
    logic [31:0] vt;
    logic [2:0]  flt;
    int          na, first, ones;
    bit          tie;
    w[0] = d0; w[1] = d1; w[2] = d2;
`ifdef CV32E40P_TMR_FAULT_INJECT_EN
    if (inj_en && inj_ch < 2'd3) w[inj_ch] = w[inj_ch] ^ inj_mask;
`endif
    if (r) begin
      e_valid = 0; e_mis = 0; e_unc = 0; e_fault = '0; e_data = '0;
      m_cnt = 0;
      for (int c = 0; c < 3; c++) begin m_failed[c] = 0; m_streak[c] = 0; end
      return;
    end
    na = 0; first = -1; vt = '0; tie = 0; flt = '0;
    for (int c = 0; c < 3; c++) if (!m_failed[c]) begin na++; if (first < 0) first = c; end
    if (na == 0) vt = w[0];
    else begin
      for (int b = 0; b < 32; b++) begin
        ones = 0;
        for (int c = 0; c < 3; c++) if (!m_failed[c] && w[c][b]) ones++;
        if (2 * ones > na) vt[b] = 1'b1;
        else if (2 * ones == na) begin vt[b] = w[first][b]; tie = 1; end
      end
    end
    for (int c = 0; c < 3; c++) flt[c] = !m_failed[c] && (w[c] != vt);
    e_valid = v;
    if (v) begin
      e_data = vt; e_mis = |flt; e_fault = flt; e_unc = tie || (na == 0);
    end else begin
      e_mis = 0; e_fault = '0; e_unc = 0;
    end
    if (cl) begin
      m_cnt = 0;
      for (int c = 0; c < 3; c++) begin m_failed[c] = 0; m_streak[c] = 0; end
    end else if (v) begin
      if ((|flt) && m_cnt < 255) m_cnt++;
      for (int c = 0; c < 3; c++) begin
        if (!m_failed[c]) begin
          if (flt[c]) begin
            m_streak[c]++;
            if (m_streak[c] >= 4) m_failed[c] = 1;
          end else m_streak[c] = 0;
        end
      end
    end
  endtask

  task automatic step(input bit v, input bit cl, input bit r, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [31:0] d2);
    valid_i = v; clr_i = cl; rst = r; data_i = {d2, d1, d0};
    model(v, cl, r, d0, d1, d2);
    @(posedge clk);
    #1;
    chk("valid_o", 64'(valid_o), 64'(e_valid));
    chk("data_o", 64'(data_o), 64'(e_data));
    chk("mismatch_o", 64'(mismatch_o), 64'(e_mis));
    chk("ch_fault_o", 64'(ch_fault_o), 64'(e_fault));
    chk("uncorrectable_o", 64'(uncorrectable_o), 64'(e_unc));
    chk("ch_failed_o", 64'(ch_failed_o), 64'({m_failed[2], m_failed[1], m_failed[0]}));
    chk("err_cnt_o", 64'(err_cnt_o), 64'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base, d [3];
    bit v, cl, r;
`ifdef CV32E40P_TMR_FAULT_INJECT_EN
    inj_en = 0; inj_ch = '0; inj_mask = '0;
`endif
    valid_i = 0; clr_i = 0; rst = 1; data_i = '0;
    @(negedge clk);
    step(0, 0, 1, 0, 0, 0);
    chk("reset_cnt", 64'(err_cnt_o), 64'd0);

    step(1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    chk("agree_data", 64'(data_o), 64'hDEADBEEF);

    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEE, 32'hDEADBEEF);
    chk("persist_failed", 64'(ch_failed_o), 64'b010);
    chk("persist_cnt", 64'(err_cnt_o), 64'd4);

    step(1, 0, 0, 32'h1, 32'hDEADBEEE, 32'h0);
    chk("tie_data", 64'(data_o), 64'h1);
    chk("tie_unc", 64'(uncorrectable_o), 64'd1);
    chk("tie_fault", 64'(ch_fault_o), 64'b100);

    step(1, 1, 0, 32'h1, 32'hDEADBEEE, 32'h0);
    chk("clr_mis", 64'(mismatch_o), 64'd1);
    chk("clr_cnt", 64'(err_cnt_o), 64'd0);
    chk("clr_failed", 64'(ch_failed_o), 64'd0);

    for (int i = 0; i < 7; i++)
      step(1, 0, 0, 32'h55AA55AA, 32'h55AA55AA, (i == 3) ? 32'h55AA55AA : 32'h55AA55AB);
    chk("recover_failed", 64'(ch_failed_o), 64'd0);
    chk("recover_cnt", 64'(err_cnt_o), 64'd6);

    step(1, 0, 0, 32'h12345678, 32'h12345678, 32'h12345678);
    step(0, 0, 0, 32'h0, 32'hFFFFFFFF, 32'h0);
    chk("idle_hold", 64'(data_o), 64'h12345678);
    step(1, 0, 1, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D);
    chk("rst_mid_valid", 64'(valid_o), 64'd0);

    // Alternate the faulty channel so nothing retires while the counter saturates.
    for (int i = 0; i < 260; i++)
      if (i % 2 == 0) step(1, 0, 0, 32'h0000FFFF, 32'h0000FFF0, 32'h0000FFF0);
      else            step(1, 0, 0, 32'h0000FFF0, 32'h0000FFFF, 32'h0000FFF0);
    chk("sat_cnt", 64'(err_cnt_o), 64'd255);

`ifdef CV32E40P_TMR_FAULT_INJECT_EN
    step(1, 1, 0, 32'h0, 32'h0, 32'h0);
    inj_en = 1; inj_ch = 2'd0; inj_mask = 32'h1;
    step(1, 0, 0, 32'h77, 32'h77, 32'h77);
    chk("inj_fault", 64'(ch_fault_o), 64'b001);
    inj_ch = 2'd3;
    step(1, 0, 0, 32'h77, 32'h77, 32'h77);
    chk("inj_oob", 64'(ch_fault_o), 64'b000);
    inj_en = 0;
`endif

    for (int i = 0; i < 600; i++) begin
      base = $urandom;
      for (int c = 0; c < 3; c++) begin
        d[c] = base;
        if ($urandom_range(0, 3) == 0) d[c] = base ^ (32'h1 << $urandom_range(0, 31));
        else if ($urandom_range(0, 7) == 0) d[c] = $urandom;
      end
      v  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 149) == 0);
      step(v, cl, r, d[0], d[1], d[2]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
